// File: rtl/controller_num_reg_hist.sv
// controller_num_reg_hist: working number register with digit entry and a DEPTH-entry undo ring
module controller_num_reg_hist #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_DIGITS = 8
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [2:0]                      num_sel,
  input  logic [WIDTH-1:0]                al_C,
  input  logic [WIDTH-1:0]                dt_data,
  input  logic [3:0]                      digit,
  output logic [WIDTH-1:0]                number_Q,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_cnt,
  output logic [$clog2(DEPTH+1)-1:0]      hist_cnt,
  output logic                            err
);
  localparam int DW = $clog2(MAX_DIGITS+1);
  localparam int HW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] number_q, number_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [HW-1:0]    hist_q, hist_d;
  logic [PW-1:0]    ptr_q, ptr_d, prev;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ring_q [DEPTH];
  logic             load, ap, bad_ap, start, push, undo_ok;
  always_comb begin
    load     = num_sel == 3'd1 || num_sel == 3'd2 || num_sel == 3'd4;
    ap       = num_sel == 3'd3;
    bad_ap   = ap && (digit > 4'd9 || dcnt_q == DW'(MAX_DIGITS));
    start    = ap && !bad_ap && dcnt_q == '0;
    push     = load || start;
    undo_ok  = num_sel == 3'd5 && hist_q != '0;
    err_d    = bad_ap || (num_sel == 3'd5 && hist_q == '0);
    prev     = ptr_q - 1'b1;
    number_d = num_sel == 3'd1 ? al_C :
               num_sel == 3'd2 ? dt_data :
               num_sel == 3'd4 ? '0 :
               start           ? WIDTH'(digit) :
               (ap && !bad_ap) ? number_q * WIDTH'(10) + WIDTH'(digit) :
               undo_ok         ? ring_q[prev] : number_q;
    dcnt_d   = (load || undo_ok) ? '0 :
               start             ? DW'(digit != 4'd0) :
               (ap && !bad_ap)   ? dcnt_q + 1'b1 : dcnt_q;
    hist_d   = push    ? (hist_q == HW'(DEPTH) ? hist_q : hist_q + 1'b1) :
               undo_ok ? hist_q - 1'b1 : hist_q;
    ptr_d    = push ? ptr_q + 1'b1 : undo_ok ? prev : ptr_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      number_q <= '0;
      dcnt_q   <= '0;
      hist_q   <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      number_q <= number_d;
      dcnt_q   <= dcnt_d;
      hist_q   <= hist_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      if (push) ring_q[ptr_q] <= number_q;
    end
  end
  assign number_Q  = number_q;
  assign digit_cnt = dcnt_q;
  assign hist_cnt  = hist_q;
  assign err       = err_q;
endmodule
